// File: rtl/relu_share_sched_if.sv
// rtl/relu_share_sched_if.sv - request, activation-unit and result signals of the shared ReLU scheduler
interface relu_share_sched_if #(
  parameter int NREQ = 4,
  parameter int IWID = 14,
  parameter int OWID = 10
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      iValid;
  logic [NREQ*IWID-1:0] iData;
  logic [NREQ-1:0]      iReady;
  logic [IWID-1:0]      actIn;
  logic [OWID-1:0]      actOut;
  logic                 oValid;
  logic [OWID-1:0]      oData;
  logic [IDW-1:0]       oId;
  logic                 oReady;
  logic                 busy;

  modport master (
    output iValid, iData, actOut, oReady,
    input  iReady, actIn, oValid, oData, oId, busy
  );

  modport slave (
    input  iValid, iData, actOut, oReady,
    output iReady, actIn, oValid, oData, oId, busy
  );
endinterface

// File: rtl/relu_share_sched.sv
// rtl/relu_share_sched.sv - round-robin sharing of one fixed-latency ReLU unit with credit-protected result FIFO
module relu_share_sched #(
  parameter int NREQ   = 4,
  parameter int IWID   = 14,
  parameter int OWID   = 10,
  parameter int LAT    = 1,
  parameter int FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  relu_share_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW  = $clog2(FDEPTH + 1);

  logic [IDW-1:0]  ptr;
  logic [LAT-1:0]  tag_v;
  logic [IDW-1:0]  tag_id [LAT];
  logic [OWID-1:0] mem_data [FDEPTH];
  logic [IDW-1:0]  mem_id [FDEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            credit_ok;
  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] req_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Results already issued to the unit hold a FIFO slot; a same-cycle pop is not credited.
  always_comb begin
    int inflight;
    inflight = 0;
    for (int i = 0; i < LAT; i++) inflight += int'(tag_v[i]);
    credit_ok = (inflight + int'(count)) < FDEPTH;
  end

  always_comb begin
    int             s;
    logic [IDW-1:0] sel;
    grant_any = 1'b0;
    grant_id  = '0;
    s         = 0;
    sel       = '0;
    if (!rst && credit_ok) begin
      for (int i = 0; i < NREQ; i++) begin
        s = int'(ptr) + i;
        if (s >= NREQ) s = s - NREQ;
        sel = IDW'(s);
        if (!grant_any && bus.iValid[sel]) begin
          grant_any = 1'b1;
          grant_id  = sel;
        end
      end
    end
  end

  assign bus.iReady = grant_any ? (NREQ'(1) << grant_id) : '0;
  assign bus.actIn  = grant_any ? bus.iData[grant_id*IWID +: IWID] : '0;

  assign push       = tag_v[LAT-1];
  assign pop        = bus.oValid && bus.oReady;
  assign bus.oValid = (count != '0);
  assign bus.oData  = bus.oValid ? mem_data[rd_ptr] : '0;
  assign bus.oId    = bus.oValid ? mem_id[rd_ptr] : '0;
  assign bus.busy   = (|tag_v) || (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      tag_v  <= '0;
      for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant_any) ptr <= req_inc(grant_id);
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      if (push) wr_ptr <= fifo_inc(wr_ptr);
      if (pop)  rd_ptr <= fifo_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Payload storage needs no reset: the occupancy counter masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.actOut;
      mem_id[wr_ptr]   <= tag_id[LAT-1];
    end
  end
endmodule

// File: tb/tb_relu_share_sched.sv
// tb/tb_relu_share_sched.sv - directed scoreboard bench for relu_share_sched
module tb_relu_share_sched;
  localparam int NREQ   = 4;
  localparam int IWID   = 14;
  localparam int OWID   = 10;
  localparam int LAT    = 1;
  localparam int FDEPTH = 4;

  typedef struct packed {
    logic [1:0]      id;
    logic [OWID-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  exp_t exp_q[$];
  logic [IWID-1:0] lane [NREQ];
  logic [OWID-1:0] act_q = '0;

  relu_share_sched_if #(.NREQ(NREQ), .IWID(IWID), .OWID(OWID)) bus ();

  relu_share_sched #(
    .NREQ(NREQ), .IWID(IWID), .OWID(OWID), .LAT(LAT), .FDEPTH(FDEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Activation unit stand-in: truncating pass-through, one register deep
  always @(posedge clk) act_q <= bus.actIn[OWID-1:0];
  assign bus.actOut = act_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic set_lanes(input int seed);
    if (seed >= 0) begin
      for (int k = 0; k < NREQ; k++) begin
        lane[k] = IWID'((seed * 37 + k * 1111 + 5) % 16384);
        bus.iData[k*IWID +: IWID] = lane[k];
      end
    end
  endtask

  task automatic step(input logic [3:0] v, input int seed, input int exp_g,
                      input string name, input bit chk_ov);
    exp_t e;
    bus.iValid = v;
    set_lanes(seed);
    @(negedge clk);
    if (exp_g < 0) begin
      chk({name, "_iready_none"}, 32'(bus.iReady), 32'd0);
      chk({name, "_actin_zero"}, 32'(bus.actIn), 32'd0);
    end else begin
      chk({name, "_iready"}, 32'(bus.iReady), 32'd1 << exp_g);
      chk({name, "_actin"}, 32'(bus.actIn), 32'(lane[exp_g]));
      e.id   = 2'(exp_g);
      e.data = lane[exp_g][OWID-1:0];
      exp_q.push_back(e);
    end
    if (chk_ov) chk({name, "_ovalid_nobubble"}, 32'(bus.oValid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.iValid = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.oValid && bus.oReady) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output actual id=%0d data=%0h required=no output", bus.oId, bus.oData);
      end else begin
        e = exp_q.pop_front();
        chk("out_id", 32'(bus.oId), 32'(e.id));
        chk("out_data", 32'(bus.oData), 32'(e.data));
      end
    end
  end

  initial begin
    bus.iValid = 4'b1111;
    bus.iData  = '0;
    bus.oReady = 1'b1;
    for (int k = 0; k < NREQ; k++) lane[k] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_iready", 32'(bus.iReady), 32'd0);
    chk("rst_ovalid", 32'(bus.oValid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_actin", 32'(bus.actIn), 32'd0);
    chk("rst_odata", 32'(bus.oData), 32'd0);
    chk("rst_oid", 32'(bus.oId), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.iValid = '0;

    // single request with 2-cycle latency
    lane[2] = 14'd100;
    bus.iData[2*IWID +: IWID] = lane[2];
    step(4'b0100, -1, 2, "t1", 1'b0);
    bus.iValid = '0;
    @(negedge clk);
    chk("t1_ovalid_c1", 32'(bus.oValid), 32'd0);
    chk("t1_busy_c1", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_ovalid_c2", 32'(bus.oValid), 32'd1);
    chk("t1_busy_c2", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_ovalid_c3", 32'(bus.oValid), 32'd0);
    chk("t1_busy_c3", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    // full load, round-robin from ptr=0
    step(4'b1000, 2, 3, "t2pre", 1'b0);
    for (int i = 0; i < 12; i++) step(4'b1111, 10 + i, i % 4, "t2", i >= 2);
    idle(4);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);
    chk("t2_busy_idle", 32'(bus.busy), 32'd0);

    // backpressure: only FDEPTH grants, head held
    bus.oReady = 1'b0;
    for (int i = 0; i < 8; i++) step(4'b1111, 30 + i, (i < 4) ? i : -1, "t3", 1'b0);
    @(negedge clk);
    chk("t3_head_valid", 32'(bus.oValid), 32'd1);
    chk("t3_head_id", 32'(bus.oId), 32'd0);
    chk("t3_head_data", 32'(bus.oData), 32'(exp_q[0].data));
    @(posedge clk); #1;

    // release from full with requests pending: push/pop at capacity, resume from ptr=0
    bus.oReady = 1'b1;
    for (int i = 0; i < 10; i++) step(4'b1111, 50 + i, (i == 0) ? -1 : (i - 1) % 4, "t5", 1'b1);
    idle(5);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // fairness with skipped requester
    step(4'b0010, 70, 1, "t4pre", 1'b0);
    step(4'b1011, 71, 3, "t4a", 1'b0);
    step(4'b1011, 72, 0, "t4b", 1'b0);
    step(4'b1011, 73, 1, "t4c", 1'b0);
    step(4'b1011, 74, 3, "t4d", 1'b0);
    idle(4);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset with one result in flight and two buffered
    bus.oReady = 1'b0;
    step(4'b1111, 80, 0, "t6a", 1'b0);
    step(4'b1111, 81, 1, "t6b", 1'b0);
    step(4'b1111, 82, 2, "t6c", 1'b0);
    chk("t6_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_ovalid", 32'(bus.oValid), 32'd0);
    chk("t6_rst_iready", 32'(bus.iReady), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.iValid = '0;
    bus.oReady = 1'b1;
    @(negedge clk);
    chk("t6_no_stale_ovalid", 32'(bus.oValid), 32'd0);
    chk("t6_no_stale_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    step(4'b1000, 90, 3, "t6d", 1'b0);
    idle(4);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/relu_share_sched.md
Name: relu_share_sched

Overview:
- Round-robin scheduler that time-shares one fixed-latency ReLU activation unit (14-bit in, 10-bit out, registered) among NREQ requesting neuron lanes.
- Accepts one activation request per cycle, drives the shared unit, and tags each result with its requester ID through a LAT-deep tag pipeline.
- Buffers results in a credit-protected output FIFO so downstream backpressure never loses data.
- Sits between the uBrain neuron accumulators and the downstream consumer of activations.

Parameters:
NREQ, 4, number of requesters (2..16); IDW = clog2(NREQ) is a derived localparam
IWID, 14, activation input width
OWID, 10, activation output width
LAT, 1, fixed latency of the external activation unit in cycles (>=1)
FDEPTH, 4, output FIFO entries (>=1); full throughput requires FDEPTH >= LAT+2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
iValid  input  NREQ  request valid, one bit per requester
iData  input  NREQ*IWID  request operands; requester k occupies bits [k*IWID +: IWID]
iReady  output  NREQ  one-hot grant; transfer on iValid[k] && iReady[k]
actIn  output  IWID  operand to shared activation unit
actOut  input  OWID  activation unit result, valid exactly LAT cycles after actIn
oValid  output  1  FIFO head valid
oData  output  OWID  FIFO head result
oId  output  IDW  FIFO head requester ID
oReady  input  1  downstream accept
busy  output  1  any tag in flight or FIFO non-empty

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async assert, sync-to-clk release): ptr=0, tag pipeline cleared, FIFO empty, credit count 0.
  - Outputs during reset: iReady=0, oValid=0, oData=0, oId=0, actIn=0, busy=0.
  - Assertion mid-operation discards all in-flight and buffered results.
- Credit rule: issue allowed iff inflight + fifoCount < FDEPTH.
  - inflight = number of valid tag stages; fifoCount is the current occupancy.
  - A same-cycle pop is not counted as freed, so the check is conservative. The FIFO can never overflow.
- Arbitration (combinational):
  - If credit is available, scan from ptr upward, mod NREQ, for the first k with iValid[k]=1.
  - Drive iReady = one-hot(k) and actIn = iData slice k. Otherwise iReady=0 and actIn=0.
  - iReady may depend combinationally on iValid; requesters must not make iValid depend on iReady.
- Pointer update: on a grant of k, ptr <= (k+1) mod NREQ; with no grant, ptr holds.
- Tag pipeline: LAT stages of {v,id}.
  - Stage 0 loads {grant, k} each cycle.
  - Stage LAT-1 output, when valid, pushes {actOut, id} into the FIFO in that cycle.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy counter (0..FDEPTH).
  - Push and pop in the same cycle are allowed at any occupancy, including full-with-pop and empty-with-push.
  - No bypass: a pushed entry is visible on oValid from the next cycle.
  - oValid = (count!=0); oData/oId = head; pop on oValid && oReady.
  - Head is stable while oValid && !oReady.
- Latency: grant in cycle t -> actOut sampled in cycle t+LAT -> oValid in cycle t+LAT+1 (default: 2 cycles).
- Throughput: one result per cycle with oReady=1 and FDEPTH >= LAT+2. Results leave in grant order.
- busy = |tagValid || count!=0.

Test Plan:
- Bench model for the activation unit: actOut = actIn[OWID-1:0] registered LAT times. Default parameters.
1. Single request: iValid=4'b0100, iData[2]=14'd100 for one cycle -> iReady=4'b0100 and actIn=100 that cycle; oValid=1, oId=2, oData=100 exactly 2 cycles later; busy high for 2 cycles, then 0.
2. Full load: iValid=4'b1111, distinct data, oReady=1 for 12 cycles -> grants 0,1,2,3,0,... one per cycle; output oId stream 0,1,2,3,... with matching data and no bubbles.
3. Backpressure: oReady=0, iValid=4'b1111 -> exactly 4 grants (ids 0,1,2,3), then iReady=0 every cycle; head {oId=0} stable. Raise oReady -> drain 0,1,2,3 in order; grants resume at ptr=0.
4. Fairness/skip: grant requester 1 (ptr=2), then iValid=4'b1011 held -> grants in order 3, 0, 1, 3.
5. Simultaneous push/pop at full: FIFO at count=4 with oReady=1 and a result arriving -> count stays 4, no data loss, order preserved.
6. Reset mid-operation: 1 result in flight, 2 in FIFO; assert rst asynchronously between edges -> oValid, iReady, busy drop to 0 immediately. After release, no stale outputs appear; first request from iValid=4'b1000 is granted to requester 3.
